// File: rtl/clk_div_prog.sv
// Programmable clock divider: registered 50% clk_out at f_clk/(2*D) plus a one-cycle tick enable.
// Latency: tick and the clk_out edge follow the wrap cycle by one clock; div_busy/div_err follow div_load by one clock.
// Backpressure: none; en freezes counting, div_load is always accepted (latest wins), zero divisor is rejected via div_err.
//
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   en             - count enable (low freezes cnt/clk_out, no tick)
//   restart        - synchronous phase restart (cnt=0, clk_out=0, applies pending divisor)
//   div_val/_load  - new half-period divisor and its one-cycle qualifying strobe
//   clk_out, tick  - divided clock and its enable pulse
//   div_busy       - a loaded divisor is waiting for the next wrap/restart
//   div_err        - pulse when a zero divisor was offered
//
// Build option: define CLK_DIV_RISE_TICK_EN to pulse tick only on clk_out 0->1 transitions.
module clk_div_prog #(
  parameter int          CNT_W    = 19,
  parameter int unsigned DIV_INIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             div_busy,
  output logic             div_err
);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] div_act, div_act_nxt;
  logic [CNT_W-1:0] div_pend, div_pend_nxt;
  logic             pend_v, pend_v_nxt;
  logic             clk_out_nxt, tick_nxt, div_err_nxt;
  logic             wrap, load_ok;

  assign load_ok = div_load && (div_val != '0);
  // div_act is never zero (zero loads are rejected), so the subtraction cannot underflow.
  assign wrap    = en && (cnt == div_act - CNT_W'(1));

  always_comb begin
    cnt_nxt      = cnt;
    div_act_nxt  = div_act;
    div_pend_nxt = div_pend;
    pend_v_nxt   = pend_v;
    clk_out_nxt  = clk_out;
    tick_nxt     = 1'b0;
    div_err_nxt  = div_load && (div_val == '0);

    if (restart) begin
      // Forcing clk_out low is a phase reset, not a divided-clock edge: no tick.
      cnt_nxt     = '0;
      clk_out_nxt = 1'b0;
      if (pend_v) begin
        div_act_nxt = div_pend;
        pend_v_nxt  = 1'b0;
      end
    end else if (wrap) begin
      cnt_nxt     = '0;
      clk_out_nxt = ~clk_out;
`ifdef CLK_DIV_RISE_TICK_EN
      tick_nxt    = ~clk_out;
`else
      tick_nxt    = 1'b1;
`endif
      if (pend_v) begin
        div_act_nxt = div_pend;
        pend_v_nxt  = 1'b0;
      end
    end else if (en) begin
      cnt_nxt = cnt + CNT_W'(1);
    end

    // A load in the same cycle as a wrap or restart is never applied there:
    // only the previously pending value is consumed, the new one stays pending.
    if (load_ok) begin
      div_pend_nxt = div_val;
      pend_v_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      div_act  <= CNT_W'(DIV_INIT);
      div_pend <= '0;
      pend_v   <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      div_act  <= div_act_nxt;
      div_pend <= div_pend_nxt;
      pend_v   <= pend_v_nxt;
      clk_out  <= clk_out_nxt;
      tick     <= tick_nxt;
      div_err  <= div_err_nxt;
    end
  end

  assign div_busy = pend_v;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed per-cycle vectors with hand-computed expected outputs.
// Latency: each vector's expectation refers to the outputs after the edge that samples its inputs.
// Backpressure: none; the monitor pops one expectation per cycle.
module tb_clk_div_prog;

  localparam int CNT_W = 19;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             restart = 1'b0;
  logic [CNT_W-1:0] div_val = '0;
  logic             div_load = 1'b0;
  logic             clk_out, tick, div_busy, div_err;

  clk_div_prog #(.CNT_W(CNT_W), .DIV_INIT(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .restart  (restart),
    .div_val  (div_val),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_busy (div_busy),
    .div_err  (div_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic clk_o;
    logic tck;
    logic busy;
    logic err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vec_idx  = 0;

  task automatic chk(input string name, input int idx, input logic act, input logic want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s vec %0d: got %0b want %0b", name, idx, act, want);
  endtask

  // Drive one input pattern for n cycles and queue the expected outputs.
  // The tick column is written for the every-toggle mode; in rise-only mode
  // a tick survives only where clk_out has just become 1.
  task automatic v(input logic r, input logic e, input logic rs, input logic ld,
                   input int val, input int n,
                   input logic ec, input logic et, input logic eb, input logic ee);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      rst      = r;
      en       = e;
      restart  = rs;
      div_load = ld;
      div_val  = CNT_W'(val);
      @(posedge clk);
      x.clk_o = ec;
`ifdef CLK_DIV_RISE_TICK_EN
      x.tck   = et & ec;
`else
      x.tck   = et;
`endif
      x.busy  = eb;
      x.err   = ee;
      exp_q.push_back(x);
      @(negedge clk);
    end
  endtask

  // Monitor: compares the DUT outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("clk_out",  vec_idx, clk_out,  e.clk_o);
        chk("tick",     vec_idx, tick,     e.tck);
        chk("div_busy", vec_idx, div_busy, e.busy);
        chk("div_err",  vec_idx, div_err,  e.err);
        vec_idx++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //  rst en rs ld val n   clk tck bsy err
    // reset state
    v(1, 1, 0, 0, 0, 2,    0, 0, 0, 0);
    // DIV_INIT=2 free run: clk_out 0,1,1,0,0,1,1,0
    v(0, 1, 0, 0, 0, 1,    0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 1,    1, 1, 0, 0);
    v(0, 1, 0, 0, 0, 1,    1, 0, 0, 0);
    v(0, 1, 0, 0, 0, 1,    0, 1, 0, 0);
    v(0, 1, 0, 0, 0, 1,    0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 1,    1, 1, 0, 0);
    v(0, 1, 0, 0, 0, 1,    1, 0, 0, 0);
    v(0, 1, 0, 0, 0, 1,    0, 1, 0, 0);
    // load 5 mid-period; applies at next wrap, then 5-cycle phases
    v(0, 1, 0, 1, 5, 1,    0, 0, 1, 0);
    v(0, 1, 0, 0, 0, 1,    1, 1, 0, 0);
    v(0, 1, 0, 0, 0, 4,    1, 0, 0, 0);
    v(0, 1, 0, 0, 0, 1,    0, 1, 0, 0);
    v(0, 1, 0, 0, 0, 4,    0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 1,    1, 1, 0, 0);
    // zero divisor: err pulse, divisor and busy unchanged
    v(0, 1, 0, 1, 0, 1,    1, 0, 0, 1);
    v(0, 1, 0, 0, 0, 3,    1, 0, 0, 0);
    v(0, 1, 0, 0, 0, 1,    0, 1, 0, 0);
    // back-to-back loads 3 then 7: only 7 applies
    v(0, 1, 0, 1, 3, 1,    0, 0, 1, 0);
    v(0, 1, 0, 1, 7, 1,    0, 0, 1, 0);
    v(0, 1, 0, 0, 0, 2,    0, 0, 1, 0);
    v(0, 1, 0, 0, 0, 1,    1, 1, 0, 0);
    v(0, 1, 0, 0, 0, 6,    1, 0, 0, 0);
    v(0, 1, 0, 0, 0, 1,    0, 1, 0, 0);
    // pending 4, then load 6 on the wrap cycle: 4 now, 6 at the next wrap
    v(0, 1, 0, 1, 4, 1,    0, 0, 1, 0);
    v(0, 1, 0, 0, 0, 5,    0, 0, 1, 0);
    v(0, 1, 0, 1, 6, 1,    1, 1, 1, 0);
    v(0, 1, 0, 0, 0, 3,    1, 0, 1, 0);
    v(0, 1, 0, 0, 0, 1,    0, 1, 0, 0);
    v(0, 1, 0, 0, 0, 5,    0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 1,    1, 1, 0, 0);
    // en low for 10 cycles mid high phase, then the remaining count
    v(0, 1, 0, 0, 0, 2,    1, 0, 0, 0);
    v(0, 0, 0, 0, 0, 10,   1, 0, 0, 0);
    v(0, 1, 0, 0, 0, 3,    1, 0, 0, 0);
    v(0, 1, 0, 0, 0, 1,    0, 1, 0, 0);
    v(0, 1, 0, 0, 0, 5,    0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 1,    1, 1, 0, 0);
    // pending 3 then restart during high phase: clk_out low, half-period 3
    v(0, 1, 0, 1, 3, 1,    1, 0, 1, 0);
    v(0, 1, 1, 0, 0, 1,    0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 2,    0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 1,    1, 1, 0, 0);
    v(0, 1, 0, 0, 0, 2,    1, 0, 0, 0);
    v(0, 1, 0, 0, 0, 1,    0, 1, 0, 0);
    // restart with a simultaneous load 5: load stays pending, 3 still active
    v(0, 1, 1, 1, 5, 1,    0, 0, 1, 0);
    v(0, 1, 0, 0, 0, 2,    0, 0, 1, 0);
    v(0, 1, 0, 0, 0, 1,    1, 1, 0, 0);
    // reset mid high phase
    v(1, 1, 0, 0, 0, 1,    0, 0, 0, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d queued want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
